// File: rtl/stack_access_unit_pkg.sv
// Shared definitions for the stack access unit: op codes, FSM states, esp write codes.
package stack_access_unit_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MEM   = 2'b01,
        S_WB    = 2'b10,
        S_FAULT = 2'b11
    } state_e;

    // Write codes understood by esp_register users
    localparam logic [3:0] ESP_WRITE = 4'h1;
    localparam logic [3:0] ESP_HOLD  = 4'h0;

    function automatic logic is_stack_op(input logic [1:0] op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/stack_access_unit_if.sv
// Command, esp-register and data-memory signals of the stack access unit.
interface stack_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] esp;
    logic [3:0]        esp_wr;
    logic [DATA_W-1:0] esp_next;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              fault;

    modport master (
        output cmd_valid, cmd_op, push_data, esp, mem_ack, mem_rdata,
        input  cmd_ready, esp_wr, esp_next, mem_req, mem_we, mem_addr,
               mem_wdata, pop_valid, pop_data, fault
    );

    modport slave (
        input  cmd_valid, cmd_op, push_data, esp, mem_ack, mem_rdata,
        output cmd_ready, esp_wr, esp_next, mem_req, mem_we, mem_addr,
               mem_wdata, pop_valid, pop_data, fault
    );
endinterface

// File: rtl/stack_access_unit_addr_calc.sv
// Combinational esp step arithmetic (modulo 2^DATA_W) and stack limit compares.
module stack_access_unit_addr_calc #(
    parameter int                DATA_W      = 32,
    parameter int                STEP        = 4,
    parameter logic [DATA_W-1:0] STACK_TOP   = 32'hffffffff,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h00001000
) (
    input  logic [DATA_W-1:0] i_esp,
    output logic [DATA_W-1:0] o_esp_dec,
    output logic [DATA_W-1:0] o_esp_inc,
    output logic              o_push_viol,
    output logic              o_pop_viol
);
    localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);
    localparam logic [DATA_W-1:0] PUSH_MIN = STACK_LIMIT + STEP_W;
    localparam logic [DATA_W-1:0] POP_MAX  = STACK_TOP - STEP_W;

    assign o_esp_dec   = i_esp - STEP_W;
    assign o_esp_inc   = i_esp + STEP_W;
    assign o_push_viol = (i_esp < PUSH_MIN);
    assign o_pop_viol  = (i_esp > POP_MAX);
endmodule

// File: rtl/stack_access_unit.sv
// PUSH/POP sequencer between the decoder, esp_register and data memory.
// Optional limit checking (FAULT state) is enabled by defining STACK_LIMIT_CHECK_EN.
module stack_access_unit
    import stack_access_unit_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                STEP        = 4,
    parameter logic [DATA_W-1:0] STACK_TOP   = 32'hffffffff,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h00001000
) (
    input logic                 clock_5,
    input logic                 reset,
    stack_access_unit_if.slave  bus
);
    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_is_push;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_esp_next;
    logic [DATA_W-1:0] r_pop_data;

    logic [DATA_W-1:0] w_esp_dec;
    logic [DATA_W-1:0] w_esp_inc;
    logic              w_push_viol;
    logic              w_pop_viol;
    logic              w_fault_go;
    logic              w_is_push;
    logic              w_start;

    stack_access_unit_addr_calc #(
        .DATA_W     (DATA_W),
        .STEP       (STEP),
        .STACK_TOP  (STACK_TOP),
        .STACK_LIMIT(STACK_LIMIT)
    ) u_addr_calc (
        .i_esp      (bus.esp),
        .o_esp_dec  (w_esp_dec),
        .o_esp_inc  (w_esp_inc),
        .o_push_viol(w_push_viol),
        .o_pop_viol (w_pop_viol)
    );

    assign w_is_push = (bus.cmd_op == OP_PUSH);

`ifdef STACK_LIMIT_CHECK_EN
    assign w_fault_go = w_is_push ? w_push_viol : w_pop_viol;
`else
    // Without the check the compares have no consumer; wrap-around is legal.
    logic w_unused_viol;
    assign w_unused_viol = w_push_viol | w_pop_viol;
    assign w_fault_go    = 1'b0;
`endif

    assign w_start = (r_state == S_IDLE) && bus.cmd_valid && is_stack_op(bus.cmd_op);

    always_ff @(posedge clock_5) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = w_fault_go ? S_FAULT : S_MEM;
            S_MEM:   if (bus.mem_ack) w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            S_FAULT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address, write data and the future esp are all fixed at accept time.
    always_ff @(posedge clock_5) begin
        if (reset) begin
            r_is_push  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_esp_next <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_start && !w_fault_go) begin
                r_is_push  <= w_is_push;
                r_addr     <= w_is_push ? w_esp_dec : bus.esp;
                r_esp_next <= w_is_push ? w_esp_dec : w_esp_inc;
                if (w_is_push) begin
                    r_wdata <= bus.push_data;
                end
            end
            if ((r_state == S_MEM) && bus.mem_ack && !r_is_push) begin
                r_pop_data <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.mem_req   = (r_state == S_MEM);
        bus.mem_we    = (r_state == S_MEM) && r_is_push;
        bus.esp_wr    = (r_state == S_WB) ? ESP_WRITE : ESP_HOLD;
        bus.pop_valid = (r_state == S_WB) && !r_is_push;
`ifdef STACK_LIMIT_CHECK_EN
        bus.fault     = (r_state == S_FAULT);
`else
        bus.fault     = 1'b0;
`endif
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.esp_next  = r_esp_next;
        bus.pop_data  = r_pop_data;
    end
endmodule

// File: tb/tb_stack_access_unit.sv
// Directed, table-driven bench for stack_access_unit (limit rows follow STACK_LIMIT_CHECK_EN).
module tb_stack_access_unit;
    import stack_access_unit_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] esp;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        fault;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] last_pop;
    vec_t tbl[6];

    stack_access_unit_if #(.DATA_W(32)) bus ();

    stack_access_unit dut (
        .clock_5(clk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.esp       = v.esp;
        bus.push_data = v.wdata;
        step();
        bus.cmd_valid = 1'b0;
        if (v.fault) begin
            chk("fault_pulse", {31'd0, bus.fault}, 32'd1);
            chk("fault_no_req", {31'd0, bus.mem_req}, 32'd0);
            chk("fault_no_espwr", {28'd0, bus.esp_wr}, 32'h0);
            step();
            chk("fault_one_cycle", {31'd0, bus.fault}, 32'd0);
            chk("fault_back_idle", {31'd0, bus.cmd_ready}, 32'd1);
            chk("fault_no_req2", {31'd0, bus.mem_req}, 32'd0);
            return;
        end
        chk("mem_req_rise", {31'd0, bus.mem_req}, 32'd1);
        chk("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, v.op == OP_PUSH});
        chk("mem_addr", bus.mem_addr, v.exp_addr);
        if (v.op == OP_PUSH) chk("mem_wdata", bus.mem_wdata, v.wdata);
        repeat (v.delay) step();
        chk("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
        chk("mem_addr_stable", bus.mem_addr, v.exp_addr);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        chk("wb_esp_wr", {28'd0, bus.esp_wr}, 32'h1);
        chk("wb_esp_next", bus.esp_next, v.exp_next);
        chk("wb_req_dropped", {31'd0, bus.mem_req}, 32'd0);
        chk("wb_pop_valid", {31'd0, bus.pop_valid}, {31'd0, v.op == OP_POP});
        if (v.op == OP_POP) chk("pop_data", bus.pop_data, v.rdata);
        step();
        chk("esp_wr_single", {28'd0, bus.esp_wr}, 32'h0);
        chk("pop_valid_single", {31'd0, bus.pop_valid}, 32'd0);
        chk("ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        last_pop = 32'h0;
        tbl[0] = '{OP_PUSH, 32'h00002000, 32'hA5A5A5A5, 32'h0, 2, 1'b0, 32'h00001FFC, 32'h00001FFC};
        tbl[1] = '{OP_POP,  32'h00001FFC, 32'h0, 32'h12345678, 1, 1'b0, 32'h00001FFC, 32'h00002000};
`ifdef STACK_LIMIT_CHECK_EN
        tbl[2] = '{OP_PUSH, 32'h00001002, 32'h11111111, 32'h0, 0, 1'b1, 32'h0, 32'h0};
        tbl[3] = '{OP_POP,  32'hFFFFFFFE, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'h0, 32'h0};
        tbl[4] = '{OP_POP,  32'hFFFFFFFB, 32'h0, 32'h55AA55AA, 0, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF};
        tbl[5] = '{OP_PUSH, 32'h00001004, 32'h00000077, 32'h0, 1, 1'b0, 32'h00001000, 32'h00001000};
`else
        tbl[2] = '{OP_PUSH, 32'h00000002, 32'h11111111, 32'h0, 0, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE};
        tbl[3] = '{OP_POP,  32'hFFFFFFFC, 32'h0, 32'hDEADBEEF, 3, 1'b0, 32'hFFFFFFFC, 32'h00000000};
        tbl[4] = '{OP_POP,  32'h00000010, 32'h0, 32'hCAFEF00D, 0, 1'b0, 32'h00000010, 32'h00000014};
        tbl[5] = '{OP_PUSH, 32'h00000000, 32'h22222222, 32'h0, 0, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC};
`endif
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.push_data = 32'h0;
        bus.esp       = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        rst = 1'b1;
        step();
        step();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_esp_wr", {28'd0, bus.esp_wr}, 32'h0);
        chk("rst_pop_valid", {31'd0, bus.pop_valid}, 32'd0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_esp_next", bus.esp_next, 32'h0);
        chk("rst_pop_data", bus.pop_data, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i]);
            if (tbl[i].op == OP_POP && !tbl[i].fault) last_pop = tbl[i].rdata;
        end
        chk("pop_data_held", bus.pop_data, last_pop);

        // NOP/reserved commands and a stray ack while idle must not start anything
        for (int i = 0; i < 2; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = (i == 0) ? OP_NOP : OP_RSVD;
            bus.mem_ack   = 1'b1;
            step();
            chk("nop_stays_idle", {31'd0, bus.cmd_ready}, 32'd1);
            chk("nop_no_req", {31'd0, bus.mem_req}, 32'd0);
            chk("nop_no_espwr", {28'd0, bus.esp_wr}, 32'h0);
        end
        bus.cmd_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        step();

        // Back-to-back with cmd_valid held and zero-wait memory: accept every 3 cycles
        bus.esp       = 32'h00000100;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("b2b_ready", {31'd0, bus.cmd_ready}, {31'd0, (k % 3) == 0});
            chk("b2b_esp_wr", {28'd0, bus.esp_wr}, ((k % 3) == 2) ? 32'h1 : 32'h0);
            if ((k % 3) == 2)
                chk("b2b_esp_next", bus.esp_next,
                    (((k - 2) / 3) % 2 == 0) ? 32'h000000FC : 32'h00000104);
            if ((k % 3) == 0) bus.cmd_op = (((k / 3) % 2) == 0) ? OP_PUSH : OP_POP;
            bus.mem_ack = bus.mem_req;
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        chk("b2b_end_idle", {31'd0, bus.cmd_ready}, 32'd1);
        step();

        // Reset while the memory request is outstanding, then a late ack
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_PUSH;
        bus.esp       = 32'h00003000;
        bus.push_data = 32'h0BADF00D;
        step();
        bus.cmd_valid = 1'b0;
        chk("rmid_req_up", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        step();
        chk("rmid_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rmid_no_espwr", {28'd0, bus.esp_wr}, 32'h0);
        chk("rmid_idle", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rmid_addr_clr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("late_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
        chk("late_ack_no_espwr", {28'd0, bus.esp_wr}, 32'h0);
        step();
        chk("late_ack_no_espwr2", {28'd0, bus.esp_wr}, 32'h0);
        chk("late_ack_idle", {31'd0, bus.cmd_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
